// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit engine.
package uart_tx_pkg;

    // Frame sequencing states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Selects which source drives the registered serial line.
    typedef enum logic [1:0] {
        START_BIT = 2'd0,
        DATA_BIT  = 2'd1,
        PAR_BIT   = 2'd2,
        STOP_BIT  = 2'd3
    } tx_sel_t;

    // Parity type encodings as seen on PAR_TYP.
    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    // Parity bit from the XOR-reduced payload: odd parity inverts it.
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        return (par_typ == ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_shifter.sv
// Payload shift register with a count of bits already placed on the line.
module uart_tx_shifter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  bit_out,
    output logic                  last_bit
);

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [CNT_W-1:0]      cnt_reg;

    // Right shift by one with zero fill at the top.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH - 1; gi++) begin : g_shift
            assign shift_next[gi] = shift_reg[gi+1];
        end
    endgenerate
    assign shift_next[DATA_WIDTH-1] = 1'b0;

    // Load resets the sent-bit count; each shift hands one more bit to the line.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (load) begin
            shift_reg <= data_in;
            cnt_reg   <= '0;
        end else if (shift) begin
            shift_reg <= shift_next;
            cnt_reg   <= cnt_reg + 1'b1;
        end
    end

    assign bit_out  = shift_reg[0];
    // All payload bits handed out: the one on the line now is the last.
    assign last_bit = (cnt_reg == CNT_W'(DATA_WIDTH));

endmodule

// File: rtl/uart_tx_core.sv
// UART transmit engine: frame FSM, parity, shadow config and line register.
module uart_tx_core
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  BAUD_TICK,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  DATA_ACK
);

    state_t  state_reg, state_next;
    logic    tx_reg, tx_next;
    logic    busy_reg, busy_next;
    logic    ack_reg, ack_next;
    logic    par_en_reg, par_en_next;
    logic    stop2_reg, stop2_next;
    logic    par_bit_reg, par_bit_next;
    logic    stop_cnt_reg, stop_cnt_next;
    logic    tx_upd;
    tx_sel_t tx_sel;
    logic    capture;
    logic    sh_load, sh_shift, sh_bit, sh_last;

    uart_tx_shifter #(
        .DATA_WIDTH(DATA_WIDTH),
        .CNT_W     (CNT_W)
    ) u_shifter (
        .CLK     (CLK),
        .RST     (RST),
        .load    (sh_load),
        .shift   (sh_shift),
        .data_in (P_DATA),
        .bit_out (sh_bit),
        .last_bit(sh_last)
    );

    // State, line and shadow configuration registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= IDLE;
            tx_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            ack_reg      <= 1'b0;
            par_en_reg   <= 1'b0;
            stop2_reg    <= 1'b0;
            par_bit_reg  <= 1'b0;
            stop_cnt_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tx_reg       <= tx_next;
            busy_reg     <= busy_next;
            ack_reg      <= ack_next;
            par_en_reg   <= par_en_next;
            stop2_reg    <= stop2_next;
            par_bit_reg  <= par_bit_next;
            stop_cnt_reg <= stop_cnt_next;
        end
    end

    // Next-state logic; nothing moves except on a baud tick (bad encodings recover at once).
    always_comb begin
        state_next    = state_reg;
        busy_next     = busy_reg;
        ack_next      = 1'b0;
        par_en_next   = par_en_reg;
        stop2_next    = stop2_reg;
        par_bit_next  = par_bit_reg;
        stop_cnt_next = stop_cnt_reg;
        tx_upd        = 1'b0;
        tx_sel        = STOP_BIT;
        sh_load       = 1'b0;
        sh_shift      = 1'b0;
        capture       = 1'b0;
        case (state_reg)
            IDLE: begin
                capture = BAUD_TICK & DATA_VALID;
            end
            START: begin
                if (BAUD_TICK) begin
                    state_next = DATA;
                    tx_upd     = 1'b1;
                    tx_sel     = DATA_BIT;
                    sh_shift   = 1'b1;
                end
            end
            DATA: begin
                if (BAUD_TICK) begin
                    tx_upd = 1'b1;
                    if (sh_last) begin
                        if (par_en_reg) begin
                            state_next = PARITY;
                            tx_sel     = PAR_BIT;
                        end else begin
                            state_next    = STOP;
                            tx_sel        = STOP_BIT;
                            stop_cnt_next = 1'b0;
                        end
                    end else begin
                        tx_sel   = DATA_BIT;
                        sh_shift = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (BAUD_TICK) begin
                    state_next    = STOP;
                    tx_upd        = 1'b1;
                    tx_sel        = STOP_BIT;
                    stop_cnt_next = 1'b0;
                end
            end
            STOP: begin
                if (BAUD_TICK) begin
                    if (stop2_reg && !stop_cnt_reg) begin
                        stop_cnt_next = 1'b1;
                    end else if (DATA_VALID) begin
                        capture = 1'b1;
                    end else begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        tx_upd     = 1'b1;
                        tx_sel     = STOP_BIT;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                tx_upd     = 1'b1;
                tx_sel     = STOP_BIT;
            end
        endcase
        // Capture overrides: latch payload and config, start a fresh frame.
        if (capture) begin
            state_next   = START;
            busy_next    = 1'b1;
            ack_next     = 1'b1;
            tx_upd       = 1'b1;
            tx_sel       = START_BIT;
            sh_load      = 1'b1;
            par_en_next  = PAR_EN;
            stop2_next   = STOP2;
            par_bit_next = parity_bit(^P_DATA, PAR_TYP);
        end
    end

    // Line source mux; the line holds whenever no update is requested.
    always_comb begin
        tx_next = tx_reg;
        if (tx_upd) begin
            case (tx_sel)
                START_BIT: tx_next = 1'b0;
                DATA_BIT:  tx_next = sh_bit;
                PAR_BIT:   tx_next = par_bit_reg;
                default:   tx_next = 1'b1;
            endcase
        end
    end

    assign TX_OUT   = tx_reg;
    assign BUSY     = busy_reg;
    assign DATA_ACK = ack_reg;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed plus randomized frames checked against an ideal bit-list model of the line.
module tb_uart_tx_core;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          BAUD_TICK = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          DATA_VALID = 1'b0;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          STOP2 = 1'b0;
    logic          TX_OUT, BUSY, DATA_ACK;

    int checks = 0;
    int errors = 0;
    int tick_div = 4;
    int tick_cnt = 0;
    logic exp_bits[$];

    uart_tx_core #(.DATA_WIDTH(DW), .CNT_W(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .BAUD_TICK (BAUD_TICK),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .STOP2     (STOP2),
        .TX_OUT    (TX_OUT),
        .BUSY      (BUSY),
        .DATA_ACK  (DATA_ACK)
    );

    always #5 CLK = ~CLK;

    // Baud tick: one pulse every tick_div clocks, changed on the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            tick_cnt = tick_cnt + 1;
            if (tick_cnt >= tick_div) tick_cnt = 0;
            BAUD_TICK = (tick_cnt == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start, payload LSB first, optional parity, one or two stops.
    task automatic build_frame(input logic [DW-1:0] d, input logic pe, input logic pt, input logic s2);
        int ones = 0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            exp_bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pe) exp_bits.push_back(((ones % 2) == 1) != pt);
        exp_bits.push_back(1'b1);
        if (s2) exp_bits.push_back(1'b1);
    endtask

    // Advance to just after the next clock edge that carried a baud tick.
    task automatic next_tick();
        int  n = 0;
        logic got = 1'b0;
        while (!got && n < 20) begin
            @(posedge CLK);
            n++;
            got = BAUD_TICK;
        end
        if (!got) chk("tick_timeout", {31'd0, got}, 32'd1);
        #1;
    endtask

    task automatic start_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                               input logic s2, input logic hold);
        int n = 0;
        build_frame(d, pe, pt, s2);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2;
        DATA_VALID = 1'b1;
        do begin
            @(posedge CLK);
            #1;
            n++;
        end while (!DATA_ACK && n < 200);
        chk("ack_seen", {31'd0, DATA_ACK}, 32'd1);
        chk("start_bit", {31'd0, TX_OUT}, {31'd0, exp_bits[0]});
        chk("busy_start", {31'd0, BUSY}, 32'd1);
        if (!hold) DATA_VALID = 1'b0;
        if (tick_div > 1) begin
            @(posedge CLK);
            #1;
            chk("ack_pulse", {31'd0, DATA_ACK}, 32'd0);
            chk("hold_start", {31'd0, TX_OUT}, 32'd0);
        end
        $display("frame data=%02h par_en=%0d par_typ=%0d stop2=%0d div=%0d len=%0d",
                 d, pe, pt, s2, tick_div, exp_bits.size());
    endtask

    task automatic run_bits(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            next_tick();
            chk($sformatf("bit%0d", i), {31'd0, TX_OUT}, {31'd0, exp_bits[i]});
            chk($sformatf("busy%0d", i), {31'd0, BUSY}, 32'd1);
            chk($sformatf("no_ack%0d", i), {31'd0, DATA_ACK}, 32'd0);
            if (tick_div > 1) begin
                @(posedge CLK);
                #1;
                chk($sformatf("hold%0d", i), {31'd0, TX_OUT}, {31'd0, exp_bits[i]});
            end
        end
    endtask

    task automatic end_idle();
        next_tick();
        chk("idle_tx", {31'd0, TX_OUT}, 32'd1);
        chk("idle_busy", {31'd0, BUSY}, 32'd0);
    endtask

    task automatic full_frame(input logic [DW-1:0] d, input logic pe, input logic pt, input logic s2);
        start_frame(d, pe, pt, s2, 1'b0);
        run_bits(1, exp_bits.size() - 1);
        end_idle();
    endtask

    initial begin
        // Reset and idle line.
        #2 RST = 1'b1;
        #1;
        chk("rst_tx", {31'd0, TX_OUT}, 32'd1);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_ack", {31'd0, DATA_ACK}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            next_tick();
            chk("idle20_tx", {31'd0, TX_OUT}, 32'd1);
            chk("idle20_busy", {31'd0, BUSY}, 32'd0);
            chk("idle20_ack", {31'd0, DATA_ACK}, 32'd0);
        end

        // 8N1, then parity with two stops (odd and even).
        full_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        full_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        full_frame(8'h3C, 1'b1, 1'b0, 1'b1);

        // Back-to-back: second capture lands on the final stop tick of the first.
        start_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        P_DATA = 8'hFF;
        run_bits(1, exp_bits.size() - 1);
        build_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        next_tick();
        chk("b2b_ack", {31'd0, DATA_ACK}, 32'd1);
        chk("b2b_start", {31'd0, TX_OUT}, 32'd0);
        chk("b2b_busy", {31'd0, BUSY}, 32'd1);
        DATA_VALID = 1'b0;
        $display("frame data=ff back-to-back len=%0d", exp_bits.size());
        run_bits(1, exp_bits.size() - 1);
        end_idle();

        // Inputs change mid-frame: the frame in flight keeps its captured values.
        start_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        run_bits(1, 3);
        P_DATA = 8'h00; PAR_EN = 1'b1; PAR_TYP = 1'b1; STOP2 = 1'b1;
        run_bits(4, exp_bits.size() - 1);
        end_idle();

        // Asynchronous reset during the fourth data bit.
        start_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        run_bits(1, 4);
        #2 RST = 1'b1;
        #1;
        chk("midrst_tx", {31'd0, TX_OUT}, 32'd1);
        chk("midrst_busy", {31'd0, BUSY}, 32'd0);
        chk("midrst_ack", {31'd0, DATA_ACK}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_tick();
            chk("postrst_tx", {31'd0, TX_OUT}, 32'd1);
            chk("postrst_busy", {31'd0, BUSY}, 32'd0);
        end
        full_frame(8'h81, 1'b0, 1'b0, 1'b0);

        // Randomized frames and tick rates, including a tick on every clock.
        for (int k = 0; k < 12; k++) begin
            logic [DW-1:0] rd;
            logic          rpe, rpt, rs2;
            tick_div = (k == 0) ? 1 : int'($urandom_range(1, 4));
            rd  = DW'($urandom);
            rpe = 1'($urandom);
            rpt = 1'($urandom);
            rs2 = 1'($urandom);
            full_frame(rd, rpe, rpt, rs2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound on total runtime.
    initial begin
        #2000000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
Parametrised UART transmit engine. It combines frame sequencing, the shift/bit counter, parity generation and line-level output muxing in one block. It succeeds the fixed 8-bit TX controller and adds:
- configurable data width
- odd/even parity select
- 1 or 2 stop bits
- a baud-tick enable, so the block runs on the system clock
- a valid/ack input handshake with back-to-back frame support

It sits between the register-file/FIFO front end and the TX pad.

Parameters:
DATA_WIDTH, 8, payload bits per frame; legal range 5..9.
CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > DATA_WIDTH.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous, active-high reset.
BAUD_TICK  input  1  one-CLK pulse per bit period; the FSM advances only on cycles with BAUD_TICK=1.
P_DATA  input  DATA_WIDTH  parallel payload; must be stable while DATA_VALID=1.
DATA_VALID  input  1  payload request; held high until DATA_ACK.
PAR_EN  input  1  1 = parity bit present.
PAR_TYP  input  1  0 = even, 1 = odd.
STOP2  input  1  1 = two stop bits, 0 = one.
TX_OUT  output  1  serial line, registered, idle high.
BUSY  output  1  registered; 1 from frame capture through last stop bit.
DATA_ACK  output  1  registered one-CLK pulse when P_DATA and the config inputs are captured.

Behaviour:
- Reset (async, any time including mid-frame):
  - state=IDLE, TX_OUT=1, BUSY=0, DATA_ACK=0, shift register and counters cleared.
  - First frame after release starts only on a new capture.
- Capture condition: CLK edge with BAUD_TICK=1, DATA_VALID=1, and state IDLE or last stop bit.
  - Latches P_DATA, PAR_EN, PAR_TYP and STOP2 into shadow registers.
  - Parity bit = ^P_DATA XOR PAR_TYP.
  - DATA_ACK=1 for exactly one CLK after that edge.
- Config or data changes after capture do not affect the frame in flight.
- All state changes and TX_OUT updates occur only on BAUD_TICK edges; between ticks, TX_OUT and BUSY hold.
- States (each lasts one tick period unless noted):
  - IDLE: TX_OUT=1, BUSY=0. On capture -> START.
  - START: TX_OUT=0, BUSY=1 -> DATA.
  - DATA: TX_OUT = shift[0] (LSB first), shifts right each tick; lasts DATA_WIDTH ticks. On the last bit: -> PARITY if shadow PAR_EN=1, else -> STOP.
  - PARITY: TX_OUT = latched parity bit -> STOP.
  - STOP: TX_OUT=1. Lasts 1 tick, or 2 if shadow STOP2=1. On the final stop tick: capture -> START (no idle gap, BUSY stays 1); else -> IDLE.
- Latency: capture edge E -> TX_OUT=0 and BUSY=1 visible after E.
- Frame length = 1 + DATA_WIDTH + PAR_EN + (1+STOP2) ticks.
- DATA_VALID high while in START/DATA/PARITY/non-final STOP: ignored, no ACK, no corruption.
- BAUD_TICK held constantly high is legal (one bit per CLK).
- Unused/illegal state encodings -> IDLE with TX_OUT=1, BUSY=0.
- No combinational path from any input to any output.

Decomposition:
- Package uart_tx_pkg:
  - state enum: IDLE, START, DATA, PARITY, STOP
  - mux select encodings: START_BIT, DATA_BIT, PAR_BIT, STOP_BIT
  - parity type constants: EVEN=0, ODD=1
- One sub-module, uart_tx_shifter:
  - DATA_WIDTH shift register plus bit counter
  - load/shift enables, serial bit out, last-bit flag
- The FSM, parity logic and output register live in uart_tx_core.

Test Plan:
- Reset then idle: RST pulse, no DATA_VALID for 20 ticks -> TX_OUT=1, BUSY=0, DATA_ACK never asserted.
- Basic 8N1 (DATA_WIDTH=8, BAUD_TICK every 4 CLK): P_DATA=0xA5, PAR_EN=0, STOP2=0 -> one-cycle DATA_ACK; TX_OUT per tick = 0,1,0,1,0,0,1,0,1,1 (10 ticks); BUSY high for exactly 10 ticks.
- Parity and two stop bits: P_DATA=0x3C, PAR_EN=1, PAR_TYP=1 (odd), STOP2=1 -> parity bit=1, frame 12 ticks, last two ticks high. Repeat with PAR_TYP=0 -> parity bit=0.
- Back-to-back: DATA_VALID held with 0x01 then 0xFF, captured at the final stop tick -> second START immediately follows the first STOP, BUSY never drops, two DATA_ACK pulses.
- Mid-frame config/data change: after capture of 0x55, change P_DATA to 0x00 and PAR_EN to 1 during DATA -> transmitted bits still 0x55, no parity bit.
- Reset mid-frame: assert RST during the 4th data bit -> TX_OUT=1 and BUSY=0 immediately (asynchronously); after release, a new frame with 0x81 is transmitted correctly.
